bcd_accumulator: RTL

- Sequential front end for the two-digit BCD adder / 7-segment display path on the DE10 board.
- Each debounced pushbutton press captures a two-digit BCD operand from the switches and adds it to a three-digit BCD running total.
- The addition runs digit-serially, ripple-carry style, one digit per clock.
- Outputs are BCD digits that feed the existing BCD-to-7-segment decoders directly, plus status flags for LEDs.

---
 rtl/bcd_accumulator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_accumulator.sv
// bcd_accumulator: adds a debounced-keypress-captured two-digit BCD operand
// to a three-digit BCD running total, one digit per clock.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_key_n                   raw active-low pushbutton (asynchronous)
//   i_clr                     synchronous clear of total and flags
//   i_op_ones, i_op_tens      BCD operand digits from the switches
//   o_d0, o_d1, o_d2          total ones/tens/hundreds digits
//   o_busy                    addition in progress (ADD0..ADD2)
//   o_done                    one-cycle pulse after the total is updated
//   o_err                     last press carried a non-BCD operand
//   o_ovf                     sticky, total wrapped past 999
module bcd_accumulator #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_n,
    input  logic       i_clr,
    input  logic [3:0] i_op_ones,
    input  logic [3:0] i_op_tens,
    output logic [3:0] o_d0,
    output logic [3:0] o_d1,
    output logic [3:0] o_d2,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_ovf
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SUM_W   = DIGIT_W + 1;
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADD0, ADD1, ADD2} state_t;

    // One BCD digit add: returns {carry, digit}
    function automatic logic [SUM_W-1:0] bcd_digit_add(
        input logic [DIGIT_W-1:0] a,
        input logic [DIGIT_W-1:0] b,
        input logic               cin
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
        if (sum > SUM_W'(9)) begin
            bcd_digit_add = {1'b1, DIGIT_W'(sum - SUM_W'(10))};
        end else begin
            bcd_digit_add = {1'b0, sum[DIGIT_W-1:0]};
        end
    endfunction

    logic             key_meta;
    logic             key_sync;
    logic             key_db;
    logic [CNT_W-1:0] db_cnt;
    logic             press_c;

    // Synchroniser and debouncer; the level only flips after a stable run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_db   <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_meta <= i_key_n;
            key_sync <= key_meta;
            if (key_sync == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                key_db <= key_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // Press event: the cycle in which the debounced level falls 1 -> 0
    assign press_c = key_db && !key_sync && (db_cnt == CNT_LAST);

    state_t             state, state_nxt;
    logic [DIGIT_W-1:0] op_ones, op_ones_nxt;
    logic [DIGIT_W-1:0] op_tens, op_tens_nxt;
    logic               carry, carry_nxt;
    logic [DIGIT_W-1:0] d0_nxt, d1_nxt, d2_nxt;
    logic               busy_nxt, done_nxt, err_nxt, ovf_nxt;
    logic [SUM_W-1:0]   add_res;

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            op_ones <= '0;
            op_tens <= '0;
            carry   <= 1'b0;
            o_d0    <= '0;
            o_d1    <= '0;
            o_d2    <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_ones <= op_ones_nxt;
            op_tens <= op_tens_nxt;
            carry   <= carry_nxt;
            o_d0    <= d0_nxt;
            o_d1    <= d1_nxt;
            o_d2    <= d2_nxt;
            o_busy  <= busy_nxt;
            o_done  <= done_nxt;
            o_err   <= err_nxt;
            o_ovf   <= ovf_nxt;
        end
    end

    // Next-state and next-output logic; i_clr dominates everything
    always_comb begin
        state_nxt   = state;
        op_ones_nxt = op_ones;
        op_tens_nxt = op_tens;
        carry_nxt   = carry;
        d0_nxt      = o_d0;
        d1_nxt      = o_d1;
        d2_nxt      = o_d2;
        done_nxt    = 1'b0;
        err_nxt     = o_err;
        ovf_nxt     = o_ovf;
        add_res     = '0;

        if (i_clr) begin
            state_nxt = IDLE;
            d0_nxt    = '0;
            d1_nxt    = '0;
            d2_nxt    = '0;
            err_nxt   = 1'b0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_c) begin
                        if ((i_op_ones > DIGIT_W'(9)) || (i_op_tens > DIGIT_W'(9))) begin
                            err_nxt = 1'b1;
                        end else begin
                            op_ones_nxt = i_op_ones;
                            op_tens_nxt = i_op_tens;
                            err_nxt     = 1'b0;
                            carry_nxt   = 1'b0;
                            state_nxt   = ADD0;
                        end
                    end
                end
                ADD0: begin
                    add_res   = bcd_digit_add(o_d0, op_ones, 1'b0);
                    d0_nxt    = add_res[DIGIT_W-1:0];
                    carry_nxt = add_res[DIGIT_W];
                    state_nxt = ADD1;
                end
                ADD1: begin
                    add_res   = bcd_digit_add(o_d1, op_tens, carry);
                    d1_nxt    = add_res[DIGIT_W-1:0];
                    carry_nxt = add_res[DIGIT_W];
                    state_nxt = ADD2;
                end
                ADD2: begin
                    add_res   = bcd_digit_add(o_d2, DIGIT_W'(0), carry);
                    d2_nxt    = add_res[DIGIT_W-1:0];
                    carry_nxt = add_res[DIGIT_W];
                    if (add_res[DIGIT_W]) begin
                        ovf_nxt = 1'b1;
                    end
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
